// File: rtl/pr3_result_capture_if.sv
// ============================================================================
// Module  : pr3_result_capture_if
// Purpose : Bundles the PR3 result stream (sink side, no backpressure) and the
//           valid/ready readout port of pr3_result_capture.
// Ports   : sink_valid/sop/eop, sink_freq[23:0], sink_phaseA/B[15:0]
//           out_valid, out_ready, out_data[39:0], out_last
//           master = producer/consumer side, slave = capture block side.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pr3_result_capture_if;
  logic        sink_valid;
  logic        sink_sop;
  logic        sink_eop;
  logic [23:0] sink_freq;
  logic [15:0] sink_phaseA;
  logic [15:0] sink_phaseB;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_data;
  logic        out_last;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_freq, sink_phaseA, sink_phaseB,
    output out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_freq, sink_phaseA, sink_phaseB,
    input  out_ready,
    output out_valid, out_data, out_last
  );
endinterface

`default_nettype wire

// File: rtl/pr3_result_capture.sv
// ============================================================================
// Module  : pr3_result_capture
// Purpose : Receives the PR3 result stream, checks frame framing and length,
//           computes dphi = phaseA - phaseB per bin and buffers whole frames.
//           Only complete frames become readable; bad frames are rolled back.
// Ports   : clk40, reset_n (async, active low)
//           bus (slave)  : sink stream in, show-ahead valid/ready readout out
//           frames_ok    : committed frame count, saturating
//           frames_err   : rejected frame count, saturating
//           overflow     : sticky, a frame was dropped because FIFO was full
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pr3_result_capture #(
  parameter int FRAME_LEN = 1024,
  parameter int DEPTH     = 2048
) (
  input  wire logic              clk40,
  input  wire logic              reset_n,
  pr3_result_capture_if.slave    bus,
  output logic [15:0]            frames_ok,
  output logic [15:0]            frames_err,
  output logic                   overflow
);

  localparam int c_ADDR = $clog2(DEPTH);
  localparam int c_CW   = $clog2(FRAME_LEN + 1);
  localparam logic [c_ADDR:0] c_PTR_ONE  = (c_ADDR+1)'(1);
  localparam logic [c_ADDR:0] c_PTR_FULL = (c_ADDR+1)'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(FRAME_LEN);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
  logic [c_ADDR:0]   r_wr, r_commit, r_rd;
  logic [c_ADDR:0]   w_wr_nxt, w_commit_nxt, w_wr_addr;
  logic [40:0]       r_mem [DEPTH];
  logic [15:0]       r_frames_ok, r_frames_err;
  logic              r_overflow;

  logic              w_wr_en, w_ok_inc, w_ovf_set;
  logic [1:0]        w_err_inc;
  logic [15:0]       w_dphi;
  logic [40:0]       w_word, w_rd_entry;
  logic              w_full_wr, w_full_commit;
  logic              w_out_valid, w_rd_fire;
  logic [16:0]       w_ok_sum, w_err_sum;

  // Two's complement subtraction wraps naturally in 16 bits.
  assign w_dphi = bus.sink_phaseA - bus.sink_phaseB;
  assign w_word = {bus.sink_eop, bus.sink_freq, w_dphi};

  // Fullness uses rd as it stands at the start of the cycle. A new frame is
  // always written from the commit point, so its space check uses commit.
  assign w_full_wr     = (r_wr - r_rd) == c_PTR_FULL;
  assign w_full_commit = (r_commit - r_rd) == c_PTR_FULL;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_wr_nxt     = r_wr;
    w_commit_nxt = r_commit;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_wr;
    w_ok_inc     = 1'b0;
    w_err_inc    = 2'd0;
    w_ovf_set    = 1'b0;
    if (bus.sink_valid) begin
      if (bus.sink_sop) begin
        // An sop in any state begins a new frame; an unfinished one is abandoned.
        if (r_state == ST_FRAME) w_err_inc = 2'd1;
        w_wr_nxt = r_commit;
        if (w_full_commit) begin
          w_err_inc   = w_err_inc + 2'd1;
          w_ovf_set   = 1'b1;
          w_state_nxt = ST_DROP;
        end else if (bus.sink_eop) begin
          // Single-beat frame can never reach FRAME_LEN (>=2).
          w_err_inc   = w_err_inc + 2'd1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_wr_en     = 1'b1;
          w_wr_addr   = r_commit;
          w_wr_nxt    = r_commit + c_PTR_ONE;
          w_cnt_nxt   = c_CNT_ONE;
          w_state_nxt = ST_FRAME;
        end
      end else begin
        case (r_state)
          ST_FRAME: begin
            if (bus.sink_eop) begin
              if (w_full_wr) begin
                w_wr_nxt    = r_commit;
                w_err_inc   = 2'd1;
                w_ovf_set   = 1'b1;
                w_state_nxt = ST_DROP;
              end else begin
                w_wr_en     = 1'b1;
                w_state_nxt = ST_IDLE;
                if (r_cnt == c_CNT_LAST) begin
                  w_wr_nxt     = r_wr + c_PTR_ONE;
                  w_commit_nxt = r_wr + c_PTR_ONE;
                  w_ok_inc     = 1'b1;
                end else begin
                  w_wr_nxt  = r_commit;
                  w_err_inc = 2'd1;
                end
              end
            end else if (r_cnt == c_CNT_MAX) begin
              w_wr_nxt    = r_commit;
              w_err_inc   = 2'd1;
              w_state_nxt = ST_DROP;
            end else if (w_full_wr) begin
              w_wr_nxt    = r_commit;
              w_err_inc   = 2'd1;
              w_ovf_set   = 1'b1;
              w_state_nxt = ST_DROP;
            end else begin
              w_wr_en   = 1'b1;
              w_wr_nxt  = r_wr + c_PTR_ONE;
              w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
          end
          ST_DROP: begin
            if (bus.sink_eop) w_state_nxt = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_ok_sum  = {1'b0, r_frames_ok}  + {16'd0, w_ok_inc};
  assign w_err_sum = {1'b0, r_frames_err} + {15'd0, w_err_inc};

  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_wr         <= '0;
      r_commit     <= '0;
      r_rd         <= '0;
      r_frames_ok  <= '0;
      r_frames_err <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wr         <= w_wr_nxt;
      r_commit     <= w_commit_nxt;
      if (w_rd_fire) r_rd <= r_rd + c_PTR_ONE;
      r_frames_ok  <= w_ok_sum[16]  ? 16'hFFFF : w_ok_sum[15:0];
      r_frames_err <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  // Storage carries no reset; only the committed region is ever read.
  always_ff @(posedge clk40) begin
    if (w_wr_en) r_mem[w_wr_addr[c_ADDR-1:0]] <= w_word;
  end

  // Show-ahead readout straight from the committed head entry; it cannot be
  // overwritten while unread, so it stays stable until accepted.
  assign w_rd_entry  = r_mem[r_rd[c_ADDR-1:0]];
  assign w_out_valid = r_rd != r_commit;
  assign w_rd_fire   = w_out_valid & bus.out_ready;

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? w_rd_entry[39:0] : 40'd0;
  assign bus.out_last  = w_out_valid & w_rd_entry[40];

  assign frames_ok  = r_frames_ok;
  assign frames_err = r_frames_err;
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pr3_result_capture.sv
// ============================================================================
// Module  : tb_pr3_result_capture
// Purpose : Self-checking bench for pr3_result_capture (FRAME_LEN=4, DEPTH=8).
//           A frame-level queue model predicts committed words; a monitor
//           process pops and compares whenever the DUT hands a word over.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pr3_result_capture;
  localparam int FL = 4;
  localparam int DP = 8;

  logic        clk40 = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] frames_ok, frames_err;
  logic        overflow;

  pr3_result_capture_if bus ();

  pr3_result_capture #(.FRAME_LEN(FL), .DEPTH(DP)) dut (
    .clk40      (clk40),
    .reset_n    (reset_n),
    .bus        (bus),
    .frames_ok  (frames_ok),
    .frames_err (frames_err),
    .overflow   (overflow)
  );

  always #12.5 clk40 = ~clk40;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  int rdy_mode = 0;       // 0: hold low, 1: hold high, 2: random
  logic [40:0] expq[$];   // expected {last, freq, dphi}, in readout order
  logic [40:0] last_word;

  // Reference model: frame under construction, committed-but-unread count,
  // mode 0 = waiting for sop, 1 = collecting, 2 = discarding until eop/sop.
  logic [40:0] cur[$];
  int mode = 0;
  int occ = 0;
  int m_ok = 0;
  int m_err = 0;
  bit m_ovf = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    cur.delete();
    mode = 0; occ = 0; m_ok = 0; m_err = 0; m_ovf = 1'b0;
  endtask

  // Predicts the effect of the inputs currently driven at the coming edge.
  task automatic model_step();
    logic [40:0] w;
    bit hs;
    hs = (occ > 0) && bus.out_ready;
    if (bus.sink_valid) begin
      w = {bus.sink_eop, bus.sink_freq, 16'(bus.sink_phaseA - bus.sink_phaseB)};
      if (bus.sink_sop) begin
        if (mode == 1) begin cur.delete(); m_err++; end
        if (occ == DP) begin m_err++; m_ovf = 1'b1; mode = 2; end
        else if (bus.sink_eop) begin m_err++; mode = 0; end
        else begin cur.push_back(w); mode = 1; end
      end else if (mode == 1) begin
        if (bus.sink_eop) begin
          if (occ + cur.size() == DP) begin
            cur.delete(); m_err++; m_ovf = 1'b1; mode = 2;
          end else begin
            cur.push_back(w);
            if (cur.size() == FL) begin
              foreach (cur[i]) expq.push_back(cur[i]);
              occ += FL;
              m_ok++;
            end else m_err++;
            cur.delete();
            mode = 0;
          end
        end else if (cur.size() == FL) begin
          cur.delete(); m_err++; mode = 2;
        end else if (occ + cur.size() == DP) begin
          cur.delete(); m_err++; m_ovf = 1'b1; mode = 2;
        end else cur.push_back(w);
      end else if (mode == 2 && bus.sink_eop) mode = 0;
    end
    if (hs) occ--;
  endtask

  task automatic drive_ready();
    case (rdy_mode)
      0: bus.out_ready = 1'b0;
      1: bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic beat(bit v, bit s, bit e, logic [23:0] f, logic [15:0] a, logic [15:0] b);
    @(posedge clk40); #1;
    bus.sink_valid = v; bus.sink_sop = s; bus.sink_eop = e;
    bus.sink_freq = f; bus.sink_phaseA = a; bus.sink_phaseB = b;
    drive_ready();
    @(negedge clk40);
    model_step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 24'd0, 16'd0, 16'd0);
  endtask

  task automatic good_frame(logic [23:0] f0, logic [15:0] a, logic [15:0] b);
    for (int i = 0; i < FL; i++) beat(1'b1, i == 0, i == FL-1, f0 + 24'(i), a, b);
  endtask

  task automatic drain(string name);
    int n = 0;
    rdy_mode = 1;
    while ((occ > 0 || expq.size() > 0) && n < 200) begin idle(1); n++; end
    idle(2);
    check({name, "_queue_empty"}, 64'(expq.size()), 64'd0);
    check({name, "_out_valid_idle"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic check_counts(string name);
    check({name, "_frames_ok"},  64'(frames_ok),  64'(m_ok));
    check({name, "_frames_err"}, 64'(frames_err), 64'(m_err));
    check({name, "_overflow"},   64'(overflow),   64'(m_ovf));
  endtask

  task automatic check_zero(string name);
    check({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_out_data"},  64'(bus.out_data),  64'd0);
    check({name, "_out_last"},  64'(bus.out_last),  64'd0);
    check({name, "_frames_ok"}, 64'(frames_ok),     64'd0);
    check({name, "_frames_err"},64'(frames_err),    64'd0);
    check({name, "_overflow"},  64'(overflow),      64'd0);
  endtask

  task automatic rnd_frame(int len, bit restart);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      beat(1'b1, (i == 0) || (restart && i == 2), i == len-1,
           24'($urandom), 16'($urandom), 16'($urandom));
    end
  endtask

  // Monitor: compares every handed-over word against the scoreboard head and
  // checks the show-ahead word holds steady while stalled.
  initial begin
    logic [40:0] prev;
    bit have_prev = 1'b0;
    bit prev_ready = 1'b0;
    forever begin
      @(negedge clk40);
      if (reset_n && bus.out_valid) begin
        if (have_prev && !prev_ready)
          check("hold_stable", 64'({bus.out_last, bus.out_data}), 64'(prev));
        if (bus.out_ready) begin
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %0h expected none at %0t",
                     {bus.out_last, bus.out_data}, $time);
          end else begin
            check("word", 64'({bus.out_last, bus.out_data}), 64'(expq.pop_front()));
            popped++;
            last_word = {bus.out_last, bus.out_data};
          end
        end
        prev = {bus.out_last, bus.out_data};
        prev_ready = bus.out_ready;
        have_prev = 1'b1;
      end else have_prev = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bus.sink_valid = 1'b0; bus.sink_sop = 1'b0; bus.sink_eop = 1'b0;
    bus.sink_freq = '0; bus.sink_phaseA = '0; bus.sink_phaseB = '0;
    bus.out_ready = 1'b0;
    #40;
    check_zero("reset");
    @(posedge clk40); #1 reset_n = 1'b1;

    // 1: good frame, dphi = 1000 - (-200) = 1200
    rdy_mode = 1; p0 = popped;
    good_frame(24'd100, 16'd1000, -16'sd200);
    drain("t1");
    check("t1_words", 64'(popped - p0), 64'd4);
    check("t1_last_word", 64'(last_word), {1'b1, 24'd103, 16'd1200});
    check_counts("t1");

    // 2: wrapping difference 32000 - (-1000) -> 16'h80E8
    good_frame(24'd200, 16'd32000, -16'sd1000);
    drain("t2");
    check("t2_dphi", 64'(last_word[15:0]), 64'h80E8);

    // 3: short frame then good frame
    p0 = popped;
    for (int i = 0; i < 3; i++) beat(1'b1, i == 0, i == 2, 24'd300 + 24'(i), 16'd5, 16'd7);
    good_frame(24'd400, 16'd10, 16'd3);
    drain("t3");
    check("t3_words", 64'(popped - p0), 64'd4);
    check_counts("t3");

    // 4: sop on 3rd beat restarts the frame
    p0 = popped;
    beat(1'b1, 1'b1, 1'b0, 24'd500, 16'd1, 16'd2);
    beat(1'b1, 1'b0, 1'b0, 24'd501, 16'd1, 16'd2);
    for (int i = 0; i < FL; i++) beat(1'b1, i == 0, i == FL-1, 24'd600 + 24'(i), 16'd9, 16'd4);
    drain("t4");
    check("t4_words", 64'(popped - p0), 64'd4);
    check("t4_last_word", 64'(last_word), {1'b1, 24'd603, 16'd5});
    check_counts("t4");

    // 5: stalled readout, third frame overflows
    rdy_mode = 0; p0 = popped;
    for (int k = 0; k < 3; k++) good_frame(24'd700 + 24'(k*16), 16'(k), 16'd0);
    idle(2);
    check("t5_overflow", 64'(overflow), 64'd1);
    check_counts("t5_stalled");
    drain("t5");
    check("t5_words", 64'(popped - p0), 64'd8);
    check_counts("t5");

    // Randomised mix of good, short, long, restarted and stray traffic.
    rdy_mode = 2;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0, 1: rnd_frame(FL, 1'b0);
        2: rnd_frame($urandom_range(2, 6), 1'b0);
        3: rnd_frame(FL + 2, 1'b1);
        default: beat(1'b1, 1'b0, 1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom), 16'($urandom));
      endcase
      idle($urandom_range(0, 2));
    end
    drain("rand");
    check_counts("rand");

    // 6: reset mid-frame with random readiness
    rdy_mode = 2;
    beat(1'b1, 1'b1, 1'b0, 24'd900, 16'd3, 16'd1);
    beat(1'b1, 1'b0, 1'b0, 24'd901, 16'd3, 16'd1);
    @(posedge clk40); #3 reset_n = 1'b0;
    model_reset();
    #1 check_zero("t6_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk40); #1 bus.sink_valid = 1'b0; drive_ready();
    end
    @(posedge clk40); #1 reset_n = 1'b1;
    p0 = popped;
    good_frame(24'd1000, 16'd50, 16'd20);
    drain("t6");
    check("t6_words", 64'(popped - p0), 64'd4);
    check("t6_last_word", 64'(last_word), {1'b1, 24'd1003, 16'd30});
    check_counts("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
